// File: rtl/posit_mult_iter.sv
// Iterative posit mantissa multiplier: radix-2^B shift-add over N/B cycles, then
// normalise and combine exponent/regime. Optional Sticky output under MULT_STICKY_EN.
module posit_mult_iter #(
    parameter int N  = 16,
    parameter int ES = 2,
    parameter int RS = $clog2(N),
    parameter int B  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              Sign1,
    input  logic              Sign2,
    input  logic [RS:0]       k1,
    input  logic [RS:0]       k2,
    input  logic [ES-1:0]     Exponent1,
    input  logic [ES-1:0]     Exponent2,
    input  logic [N-1:0]      Mantissa1,
    input  logic [N-1:0]      Mantissa2,
    input  logic              inf1,
    input  logic              inf2,
    input  logic              zero1,
    input  logic              zero2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*N-1:0]    Mult_Mant_N,
    output logic [ES-1:0]     E_O,
    output logic [RS+2:0]     R_O,
    output logic [RS+2:0]     sumR,
    output logic              inf,
    output logic              zero,
    output logic              Sign
`ifdef MULT_STICKY_EN
    ,
    output logic              Sticky
`endif
);

    localparam int STEPS = N / B;
    localparam int CW    = $clog2(STEPS) + 1;

    if (N % B != 0) begin : g_bad_digit_width
        $error("posit_mult_iter: N must be a multiple of B");
    end

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t            state, state_nxt;
    logic [2*N-1:0]    mcand_q;
    logic [N-1:0]      mplr_q;
    logic [CW-1:0]     step_q;
    logic [2*N-1:0]    acc_q;
    logic [RS:0]       k1_q, k2_q;
    logic [ES-1:0]     e1_q, e2_q;
    logic              sign_q;
    logic              special;

    logic [2*N-1:0]    pp;
    logic              msb;
    logic [2*N-1:0]    mant_norm;
    logic [ES:0]       sum_e;
    logic signed [RS+2:0] sum_r;
    logic [RS+2:0]     r_o;

    assign special = inf1 | inf2 | zero1 | zero2;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next-state defaults to the current state first, so no path leaves
    // state_nxt unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = special ? DONE : MUL;
            MUL:  if (step_q == CW'(STEPS - 1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !reset;
        out_valid = (state == DONE);
    end

    // One radix-2^B digit: the multiplicand is pre-shifted each step, so only
    // the low B multiplier bits select shifted copies of it.
    always_comb begin
        pp = '0;
        for (int i = 0; i < B; i++) begin
            if (mplr_q[i]) pp = pp + (mcand_q << i);
        end
    end

    always_comb begin
        msb       = acc_q[2*N-1];
        mant_norm = msb ? acc_q : (acc_q << 1);
        sum_e     = {1'b0, e1_q} + {1'b0, e2_q} + (ES+1)'(msb);
        sum_r     = $signed({{2{k1_q[RS]}}, k1_q}) + $signed({{2{k2_q[RS]}}, k2_q})
                  + $signed({{(RS+2){1'b0}}, sum_e[ES]});
        r_o       = sum_r[RS+2] ? RS'(0) - sum_r : sum_r + (RS+3)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q     <= '0;
            mplr_q      <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            e1_q        <= '0;
            e2_q        <= '0;
            sign_q      <= 1'b0;
            Mult_Mant_N <= '0;
            E_O         <= '0;
            R_O         <= '0;
            sumR        <= '0;
            inf         <= 1'b0;
            zero        <= 1'b0;
            Sign        <= 1'b0;
`ifdef MULT_STICKY_EN
            Sticky      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mcand_q <= {{N{1'b0}}, Mantissa1};
                    mplr_q  <= Mantissa2;
                    step_q  <= '0;
                    acc_q   <= '0;
                    k1_q    <= k1;
                    k2_q    <= k2;
                    e1_q    <= Exponent1;
                    e2_q    <= Exponent2;
                    sign_q  <= Sign1 ^ Sign2;
                    if (special) begin
                        Mult_Mant_N <= '0;
                        E_O         <= '0;
                        R_O         <= '0;
                        sumR        <= '0;
                        inf         <= inf1 | inf2;
                        zero        <= zero1 | zero2;
                        Sign        <= Sign1 ^ Sign2;
`ifdef MULT_STICKY_EN
                        Sticky      <= 1'b0;
`endif
                    end
                end
                MUL: begin
                    acc_q   <= acc_q + pp;
                    mcand_q <= mcand_q << B;
                    mplr_q  <= mplr_q >> B;
                    step_q  <= step_q + CW'(1);
                end
                NORM: begin
                    Mult_Mant_N <= mant_norm;
                    E_O         <= sum_e[ES-1:0];
                    sumR        <= sum_r;
                    R_O         <= r_o;
                    inf         <= 1'b0;
                    zero        <= 1'b0;
                    Sign        <= sign_q;
`ifdef MULT_STICKY_EN
                    Sticky      <= |mant_norm[N-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
